// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO read-port consumer that serialises each popped byte as a UART frame.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int RD_LATENCY   = 1
) (
   input  logic       rd_clk,
   input  logic       rd_rst,
   input  logic       tx_enable,
   input  logic       fifo_empty,
   input  logic [7:0] rd_data,
   output logic       rd_en,
   output logic       tx_serial,
   output logic       tx_busy,
   output logic       byte_done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);

`ifdef FIFO_UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_STOP
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             rd_en_q, rd_en_d;
   logic             tx_serial_q, tx_serial_d;
   logic             tx_busy_q, tx_busy_d;
   logic             byte_done_q, byte_done_d;
   logic             bit_tick;
   logic             can_fetch;
`ifdef FIFO_UART_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   assign bit_tick  = (cnt_q == CNT_LAST);
   assign can_fetch = tx_enable && !fifo_empty;

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      lat_d   = '0;
      bit_d   = bit_q;
      shift_d = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (can_fetch) state_d = S_FETCH;
         end
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            if (lat_q == LAT_LAST) begin
               shift_d = rd_data;
`ifdef FIFO_UART_TX_PARITY_EN
               parity_d = ^rd_data;
`endif
               state_d = S_START;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         S_START: begin
            if (bit_tick) begin
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (bit_tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_tick) state_d = S_STOP;
            else          cnt_d   = cnt_q + 1'b1;
         end
`endif
         S_STOP: begin
            // Empty flag is only looked at here and in IDLE, so a late-clearing flag just delays the fetch.
            if (bit_tick) state_d = can_fetch ? S_FETCH : S_IDLE;
            else          cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are derived from the next state.
      rd_en_d     = (state_d == S_FETCH);
      tx_busy_d   = (state_d != S_IDLE);
      byte_done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
      case (state_d)
         S_START:  tx_serial_d = 1'b0;
         S_DATA:   tx_serial_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: tx_serial_d = parity_d;
`endif
         default:  tx_serial_d = 1'b1;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         lat_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         rd_en_q     <= 1'b0;
         tx_serial_q <= 1'b1;
         tx_busy_q   <= 1'b0;
         byte_done_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lat_q       <= lat_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         rd_en_q     <= rd_en_d;
         tx_serial_q <= tx_serial_d;
         tx_busy_q   <= tx_busy_d;
         byte_done_q <= byte_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   assign rd_en     = rd_en_q;
   assign tx_serial = tx_serial_q;
   assign tx_busy   = tx_busy_q;
   assign byte_done = byte_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx with a queue-backed FIFO model.
module tb_fifo_uart_tx;
   localparam int CPB = 4;
   localparam int LAT = 1;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rd_rst = 1'b1;
   logic       tx_enable = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] rd_data = 8'h00;
   logic       rd_en, tx_serial, tx_busy, byte_done;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .RD_LATENCY(LAT)) dut (
      .rd_clk(clk), .rd_rst(rd_rst), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
      .rd_data(rd_data), .rd_en(rd_en), .tx_serial(tx_serial), .tx_busy(tx_busy),
      .byte_done(byte_done)
   );

   always #5 clk = ~clk;

   int         n_assert = 0;
   int         n_fail = 0;
   int         rd_en_cnt = 0;
   int         bd_cnt = 0;
   int         empty_viol = 0;
   logic [7:0] fq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      fq.push_back(b);
      fifo_empty = 1'b0;
   endtask

   // FIFO model pops on rd_en so data is valid one cycle later at the capture edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rd_en === 1'b1) begin
         rd_en_cnt++;
         if (fq.size() == 0) empty_viol++;
         else rd_data = fq.pop_front();
         fifo_empty = (fq.size() == 0);
      end
      if (byte_done === 1'b1) bd_cnt++;
   endtask

   task automatic wait_start(output bit ok);
      int t = 0;
      while (tx_serial !== 1'b0 && t < 400) begin
         tick();
         t++;
      end
      ok = (tx_serial === 1'b0);
   endtask

   task automatic capture_frame(input int drop_k, output logic [10:0] bits, output int done_at,
                                output bit ok, output bit stable);
      bits = '1;
      done_at = -1;
      stable = 1'b1;
      wait_start(ok);
      if (ok) begin
         for (int k = 0; k < NB * CPB; k++) begin
            if (k > 0) tick();
            if (k == drop_k) tx_enable = 1'b0;
            if (k % CPB == 0) bits[k / CPB] = tx_serial;
            else if (tx_serial !== bits[k / CPB]) stable = 1'b0;
            if (byte_done === 1'b1 && done_at < 0) done_at = k;
         end
      end
   endtask

   function automatic logic [10:0] exp_frame(input logic [7:0] d);
`ifdef FIFO_UART_TX_PARITY_EN
      return {1'b1, ^d, d, 1'b0};
`else
      return {2'b11, d, 1'b0};
`endif
   endfunction

   logic [10:0] bits;
   int          done_at;
   int          gap;
   int          bd0;
   bit          ok, stable;

   initial begin
      // Reset held with a byte pending and transmit enabled
      push(8'hA5);
      tx_enable = 1'b1;
      rd_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_tx_serial", tx_serial, 1'b1);
         check("rst_rd_en", rd_en, 1'b0);
         check("rst_tx_busy", tx_busy, 1'b0);
      end
      rd_rst = 1'b0;

      // Single byte 0xA5
      capture_frame(-1, bits, done_at, ok, stable);
      check("a5_started", ok, 1'b1);
      check("a5_bits", bits, exp_frame(8'hA5));
      check("a5_stable", stable, 1'b1);
      check("a5_done_at", done_at, NB * CPB - 1);
      tick();
      check("a5_idle_busy", tx_busy, 1'b0);
      repeat (5) tick();
      check("a5_rd_en_cnt", rd_en_cnt, 1);
      check("a5_byte_done_cnt", bd_cnt, 1);

      // Back-to-back 0x00 then 0xFF
      push(8'h00);
      push(8'hFF);
      capture_frame(-1, bits, done_at, ok, stable);
      check("b2b0_bits", bits, exp_frame(8'h00));
      check("b2b0_done_at", done_at, NB * CPB - 1);
      gap = 0;
      tick();
      while (tx_serial === 1'b1 && gap < 50) begin
         gap++;
         tick();
      end
      check("b2b_gap", gap, 2);
      capture_frame(-1, bits, done_at, ok, stable);
      check("b2b1_bits", bits, exp_frame(8'hFF));
      check("b2b1_stable", stable, 1'b1);
      repeat (5) tick();
      check("b2b_rd_en_cnt", rd_en_cnt, 3);
      check("b2b_byte_done_cnt", bd_cnt, 3);

      // Disabled with data pending, then disable during data bit 2
      tx_enable = 1'b0;
      push(8'h5A);
      push(8'h11);
      repeat (100) tick();
      check("dis_rd_en_cnt", rd_en_cnt, 3);
      check("dis_busy", tx_busy, 1'b0);
      tx_enable = 1'b1;
      capture_frame(4 + 2 * CPB + 1, bits, done_at, ok, stable);
      check("drop_bits", bits, exp_frame(8'h5A));
      check("drop_done_at", done_at, NB * CPB - 1);
      repeat (20) tick();
      check("drop_rd_en_cnt", rd_en_cnt, 4);
      check("drop_byte_done_cnt", bd_cnt, 4);
      check("drop_idle_busy", tx_busy, 1'b0);
      fq.delete();
      fifo_empty = 1'b1;

      // Reset during data bit 3 of 0x3C, then 0x96 goes out whole
      tx_enable = 1'b1;
      push(8'h3C);
      push(8'h96);
      wait_start(ok);
      check("rst_mid_started", ok, 1'b1);
      for (int k = 1; k <= CPB + 3 * CPB + 1; k++) tick();
      check("rst_mid_bit3", tx_serial, 1'b1);
      bd0 = bd_cnt;
      rd_rst = 1'b1;
      tick();
      rd_rst = 1'b0;
      check("rst_mid_tx_serial", tx_serial, 1'b1);
      check("rst_mid_busy", tx_busy, 1'b0);
      check("rst_mid_rd_en", rd_en, 1'b0);
      check("rst_mid_byte_done", byte_done, 1'b0);
      capture_frame(-1, bits, done_at, ok, stable);
      check("after_rst_bits", bits, exp_frame(8'h96));
      check("after_rst_done_at", done_at, NB * CPB - 1);
      repeat (5) tick();
      check("after_rst_byte_done_cnt", bd_cnt, bd0 + 1);
      check("after_rst_rd_en_cnt", rd_en_cnt, 6);

`ifdef FIFO_UART_TX_PARITY_EN
      // Even parity: 0x07 has three ones, 0x03 has two
      push(8'h07);
      push(8'h03);
      capture_frame(-1, bits, done_at, ok, stable);
      check("par07_parity_bit", bits[9], 1'b1);
      check("par07_frame_len", done_at + 1, 44);
      check("par07_bits", bits, 11'b111_0000_0111_0 >> 0);
      capture_frame(-1, bits, done_at, ok, stable);
      check("par03_parity_bit", bits[9], 1'b0);
      check("par03_bits", bits, 11'b100_0000_0110);
      repeat (5) tick();
`endif

      check("rd_en_while_empty", empty_viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
